fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end.
//
// Issues sequential word fetches to an in-order memory port. It keeps at most
// DEPTH requests in flight plus buffered, so every response always has a free
// FIFO slot. Instructions are presented to the decoder from a DEPTH-entry FIFO
// of {pc, inst}. A redirect flushes the FIFO, restarts fetch at a new PC and
// marks every still-outstanding response as stale so that it is dropped on
// arrival.
//
// Ports
//   clk_i, rstn_i         clock, asynchronous active-low reset
//   mem_req_o/mem_addr_o  fetch request and its word address (byte addr >> 2)
//   mem_gnt_i             request accepted this cycle
//   mem_rvalid_i/rdata_i  in-order read response
//   inst_valid_o/ready_i  decoder handshake
//   inst_o/inst_pc_o      buffered instruction word and its byte address
//   redirect_i/pc_i       flush and restart fetch at redirect_pc_i (bits [1:0] ignored)
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  output logic              mem_req_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;
  localparam logic [CNT_W:0]  DEPTH_C   = (CNT_W+1)'(DEPTH);
  localparam logic [WA_W-1:0] RESET_WPC = RESET_PC[ADDR_W-1:2];

  // PCs are kept as word addresses; the two low byte bits are always zero.
  logic [WA_W-1:0]  fetch_wpc_q, fetch_wpc_d;
  logic [WA_W-1:0]  rsp_wpc_q, rsp_wpc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [WA_W-1:0]  fifo_wpc_q [DEPTH];
  logic [WA_W-1:0]  fifo_wpc_d [DEPTH];
  logic [31:0]      fifo_inst_q [DEPTH];
  logic [31:0]      fifo_inst_d [DEPTH];

  logic [CNT_W:0] occupancy;
  logic           grant;
  logic           rsp_vld;
  logic           rsp_keep;
  logic           pop;
  logic           unused_pc_bits;

  // A response with nothing outstanding can only be a leftover from before
  // reset; ignoring it keeps the counters from underflowing.
  assign rsp_vld  = mem_rvalid_i && (outst_q != '0);
  assign rsp_keep = rsp_vld && (discard_q == '0) && !redirect_i;

  // Counting buffered plus in-flight entries reserves a FIFO slot for every
  // request at issue time, so the FIFO can never overflow. The sum only grows
  // on a grant, which keeps a raised request (and its address) stable until
  // it is accepted.
  assign occupancy  = {1'b0, count_q} + {1'b0, outst_q};
  assign mem_req_o  = rstn_i && !redirect_i && (occupancy < DEPTH_C);
  assign mem_addr_o = fetch_wpc_q;
  assign grant      = mem_req_o && mem_gnt_i;

  assign inst_valid_o = (count_q != '0);
  assign pop          = inst_valid_o && inst_ready_i;
  assign inst_o       = inst_valid_o ? fifo_inst_q[rd_ptr_q] : '0;
  assign inst_pc_o    = inst_valid_o ? {fifo_wpc_q[rd_ptr_q], 2'b00} : '0;

  assign unused_pc_bits = ^redirect_pc_i[1:0];

  always_comb begin
    fetch_wpc_d = fetch_wpc_q;
    rsp_wpc_d   = rsp_wpc_q;
    count_d     = count_q;
    outst_d     = outst_q;
    discard_d   = discard_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fifo_wpc_d  = fifo_wpc_q;
    fifo_inst_d = fifo_inst_q;

    if (rsp_keep) begin
      fifo_wpc_d[wr_ptr_q]  = rsp_wpc_q;
      fifo_inst_d[wr_ptr_q] = mem_rdata_i;
    end

    if (redirect_i) begin
      // Everything still in flight belongs to the old stream; a response
      // arriving this very cycle is already dropped, so it is not counted.
      fetch_wpc_d = redirect_pc_i[ADDR_W-1:2];
      rsp_wpc_d   = redirect_pc_i[ADDR_W-1:2];
      count_d     = '0;
      rd_ptr_d    = wr_ptr_q;
      outst_d     = outst_q - CNT_W'(rsp_vld);
      discard_d   = outst_q - CNT_W'(rsp_vld);
    end else begin
      if (grant) begin
        fetch_wpc_d = fetch_wpc_q + WA_W'(1);
      end
      outst_d = outst_q + CNT_W'(grant) - CNT_W'(rsp_vld);
      if (rsp_keep) begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        rsp_wpc_d = rsp_wpc_q + WA_W'(1);
      end
      if (rsp_vld && (discard_q != '0)) begin
        discard_d = discard_q - CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(rsp_keep) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fetch_wpc_q <= RESET_WPC;
      rsp_wpc_q   <= RESET_WPC;
      count_q     <= '0;
      outst_q     <= '0;
      discard_q   <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      fetch_wpc_q <= fetch_wpc_d;
      rsp_wpc_q   <= rsp_wpc_d;
      count_q     <= count_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // FIFO storage carries no reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    fifo_wpc_q  <= fifo_wpc_d;
    fifo_inst_q <= fifo_inst_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- randomized scoreboard bench for fetch_unit.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rstn;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        w_req;
  logic [13:0] w_addr;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [15:0] w_inst_pc;

  fetch_unit #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
    .inst_o(inst), .inst_pc_o(inst_pc),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc)
  );

  // Second instance near the top of a 16-bit address space to see the wrap.
  fetch_unit #(.ADDR_W(16), .DEPTH(4), .RESET_PC(16'hFFF8)) dut_w (
    .clk_i(clk), .rstn_i(rstn),
    .mem_req_o(w_req), .mem_addr_o(w_addr), .mem_gnt_i(1'b1),
    .mem_rvalid_i(1'b0), .mem_rdata_i(32'h0),
    .inst_valid_o(w_valid), .inst_ready_i(1'b0),
    .inst_o(w_inst), .inst_pc_o(w_inst_pc),
    .redirect_i(1'b0), .redirect_pc_i(16'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: an odd multiplier makes every word address map to a
  // distinct instruction word.
  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    return ({2'b00, wa} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference state: program-order byte PCs of the live stream.
  logic [31:0] exp_q[$];
  logic [29:0] pending[$];
  logic [31:0] model_pc = 32'h0;
  int  gnt_mode = 2;     // 0 random, 1 always, 2 never
  int  gnt_pct  = 100;
  int  rsp_pct  = 100;
  int  hs_cnt   = 0;
  int  gnt_cnt  = 0;
  bit  coincide = 0;
  bit  prev_stall = 0;
  bit  prev_redirect = 0;
  logic [31:0] prev_inst = '0;
  logic [31:0] prev_pc = '0;

  // Memory responder: grants per mode, answers in order after >= 1 cycle.
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rstn) begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      end else begin
        case (gnt_mode)
          0:       mem_gnt = ($urandom_range(99) < gnt_pct);
          1:       mem_gnt = 1'b1;
          default: mem_gnt = 1'b0;
        endcase
        if (pending.size() != 0 && $urandom_range(99) < rsp_pct) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(pending.pop_front());
        end else begin
          mem_rvalid = 1'b0;
          mem_rdata  = $urandom;
        end
      end
    end
  end

  // Monitor / scoreboard: evaluates each cycle mid-way between edges.
  always @(negedge clk) begin
    if (rstn) begin
      if (inst_valid && inst_ready) begin
        logic [31:0] e;
        hs_cnt++;
        check("inst_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e);
          check("inst_word", inst, mem_word(e[31:2]));
        end
      end
      if (prev_stall && !prev_redirect) begin
        check("hold_valid", 32'(inst_valid), 32'd1);
        check("hold_pc", inst_pc, prev_pc);
        check("hold_inst", inst, prev_inst);
      end
      if (prev_redirect) check("valid_after_redirect", 32'(inst_valid), 32'd0);
      if (redirect) begin
        check("req_during_redirect", 32'(mem_req), 32'd0);
        coincide = mem_rvalid && inst_valid && inst_ready;
        exp_q.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
      end else if (mem_req && mem_gnt) begin
        check("req_addr", {2'b00, mem_addr}, {2'b00, model_pc[31:2]});
        exp_q.push_back(model_pc);
        pending.push_back(mem_addr);
        model_pc = model_pc + 32'd4;
        gnt_cnt++;
        check("outstanding_bound", 32'(pending.size() <= DEPTH), 32'd1);
      end
      prev_stall    = inst_valid && !inst_ready;
      prev_redirect = redirect;
      prev_pc       = inst_pc;
      prev_inst     = inst;
    end
  end

  task automatic drain();
    bit done = 0;
    gnt_mode = 2; rsp_pct = 100; inst_ready = 1'b1; redirect = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      #1;
      done = (exp_q.size() == 0) && (pending.size() == 0) && !inst_valid;
    end
    check("drain_done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // 16-bit wrap instance: always granted, never answered.
  initial begin
    logic [13:0] wexp [4];
    wexp[0] = 14'h3FFE; wexp[1] = 14'h3FFF; wexp[2] = 14'h0000; wexp[3] = 14'h0001;
    @(posedge rstn);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wrap_req", 32'(w_req), 32'd1);
      check("wrap_addr", 32'(w_addr), 32'(wexp[i]));
    end
    @(negedge clk);
    check("wrap_req_full", 32'(w_req), 32'd0);
    check("wrap_valid", 32'(w_valid), 32'd0);
    check("wrap_inst", w_inst, 32'd0);
    check("wrap_inst_pc", 32'(w_inst_pc), 32'd0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    int g0;
    logic [29:0] a0;
    bit seen;
    rstn = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_wrap_req", 32'(w_req), 32'd0);

    // Streaming: always granted, 1-cycle responses, decoder always ready.
    @(posedge clk);
    #1;
    rstn = 1'b1; inst_ready = 1'b1; gnt_mode = 1; rsp_pct = 100;
    @(negedge clk);
    check("req_after_reset", 32'(mem_req), 32'd1);
    check("addr_after_reset", {2'b00, mem_addr}, 32'd0);
    repeat (20) @(negedge clk);
    #1;
    hs0 = hs_cnt;
    repeat (10) @(negedge clk);
    #1;
    check("throughput", 32'(hs_cnt - hs0), 32'd10);
    @(posedge clk);
    #1;
    drain();

    // Backpressure: fill to DEPTH, then release a single slot.
    inst_ready = 1'b0; gnt_mode = 1; rsp_pct = 100; g0 = gnt_cnt;
    repeat (10) @(negedge clk);
    #1;
    check("fill_grants", 32'(gnt_cnt - g0), 32'd4);
    check("req_when_full", 32'(mem_req), 32'd0);
    check("valid_when_full", 32'(inst_valid), 32'd1);
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    @(posedge clk);
    #1;
    inst_ready = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("one_more_grant", 32'(gnt_cnt - g0), 32'd5);
    check("req_refull", 32'(mem_req), 32'd0);
    @(posedge clk);
    #1;
    drain();

    // Grant withheld: request and address must hold.
    @(negedge clk);
    a0 = mem_addr;
    check("stall_req", 32'(mem_req), 32'd1);
    check("stall_addr_model", {2'b00, a0}, {2'b00, model_pc[31:2]});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req_hold", 32'(mem_req), 32'd1);
      check("stall_addr_hold", {2'b00, mem_addr}, {2'b00, a0});
    end

    // Three outstanding, then redirect to 0x103.
    @(posedge clk);
    #1;
    gnt_mode = 1; rsp_pct = 0;
    repeat (3) begin @(posedge clk); #1; end
    check("three_outstanding", 32'(pending.size()), 32'd3);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    @(posedge clk);
    #1;
    redirect = 1'b0; rsp_pct = 100;
    @(negedge clk);
    check("redir_req", 32'(mem_req), 32'd1);
    check("redir_addr", {2'b00, mem_addr}, 32'h40);
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      if (inst_valid) seen = 1;
      else @(negedge clk);
    end
    check("redir_first_seen", 32'(seen), 32'd1);
    check("redir_first_pc", inst_pc, 32'h100);

    // Redirect on a cycle with a response and a handshake.
    repeat (10) begin @(posedge clk); #1; end
    redirect = 1'b1; redirect_pc = 32'h0000_2000;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    check("redir_coincide", 32'(coincide), 32'd1);
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (inst_valid) seen = 1;
    end
    check("redir2_first_seen", 32'(seen), 32'd1);
    check("redir2_first_pc", inst_pc, 32'h2000);

    // Random traffic with occasional redirects.
    @(posedge clk);
    #1;
    gnt_mode = 0; gnt_pct = 70; rsp_pct = 60;
    repeat (3000) begin
      @(posedge clk);
      #1;
      inst_ready  = ($urandom_range(99) < 75);
      redirect    = ($urandom_range(99) < 3);
      redirect_pc = $urandom;
    end
    @(posedge clk);
    #1;
    drain();
    check("final_idle", 32'(inst_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
